// File: rtl/wci_pkg.sv
// Shared WCI request/response encodings, request field layout and control-op codes.
// Pure definitions; no latency or flow control of its own.
package wci_pkg;

    localparam logic [2:0] MCMD_WR = 3'b001;
    localparam logic [2:0] MCMD_RD = 3'b010;

    localparam logic [1:0] SRESP_NULL = 2'b00;
    localparam logic [1:0] SRESP_DVA  = 2'b01;
    localparam logic [1:0] SRESP_ERR  = 2'b11;

    localparam int REQ_MCMD_LSB  = 57;
    localparam int REQ_SPACE_BIT = 56;
    localparam int REQ_BE_LSB    = 52;
    localparam int REQ_ADDR_LSB  = 32;
    localparam int REQ_DATA_LSB  = 0;
    localparam int REQ_W         = 60;

    typedef struct packed {
        logic [2:0]  mcmd;
        logic        space;
        logic [3:0]  byte_en;
        logic [19:0] addr;
        logic [31:0] data;
    } wci_req_t;

    typedef enum logic [2:0] {
        CTL_EXISTS      = 3'd0,
        CTL_INITIALIZED = 3'd1,
        CTL_OPERATING   = 3'd2,
        CTL_SUSPENDED   = 3'd3
    } ctl_state_t;

    typedef enum logic [1:0] {
        REQ_IDLE = 2'd0,
        REQ_EXEC = 2'd1,
        REQ_RESP = 2'd2
    } req_fsm_t;

    localparam logic [2:0] OP_INIT    = 3'd0;
    localparam logic [2:0] OP_START   = 3'd1;
    localparam logic [2:0] OP_STOP    = 3'd2;
    localparam logic [2:0] OP_RELEASE = 3'd3;

    localparam logic [31:0] CTL_RESULT_OK  = 32'hC0DE_4201;
    localparam logic [31:0] CTL_RESULT_BAD = 32'hC0DE_4202;

    function automatic logic [31:0] be_merge(input logic [31:0] old_dat,
                                             input logic [31:0] new_dat,
                                             input logic [3:0]  be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = be[i] ? new_dat[8*i +: 8] : old_dat[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/wci_req_target_if.sv
// Request-FIFO head and WCI response signals between the FIFO/host side and the target.
// No latency; the target pops with req_deq, responses are unacknowledged single-cycle strobes.
interface wci_req_target_if;
    logic [59:0] req_d_out;
    logic        req_empty_n;
    logic        req_deq;
    logic [1:0]  wciS0_SResp;
    logic [31:0] wciS0_SData;

    modport master (output req_d_out, output req_empty_n,
                    input  req_deq, input wciS0_SResp, input wciS0_SData);
    modport slave  (input  req_d_out, input req_empty_n,
                    output req_deq, output wciS0_SResp, output wciS0_SData);
endinterface

// File: rtl/wci_cfg_regfile.sv
// NREG x 32 config register file with byte-enable write and combinational read.
// Write lands on the next clock edge; no backpressure, a write is always accepted.
module wci_cfg_regfile
    import wci_pkg::*;
#(
    parameter int NREG = 8,
    parameter int RAW  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [RAW-1:0]     wr_idx,
    input  logic [3:0]         wr_be,
    input  logic [31:0]        wr_dat,
    input  logic [RAW-1:0]     rd_idx,
    output logic [31:0]        rd_dat,
    output logic [NREG*32-1:0] regs_flat
);

    logic [31:0] regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREG; k++) begin
                regs[k] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_idx] <= be_merge(regs[wr_idx], wr_dat, wr_be);
        end
    end

    assign rd_dat = regs[rd_idx];

    for (genvar k = 0; k < NREG; k++) begin : g_flat
        assign regs_flat[32*k +: 32] = regs[k];
    end

endmodule

// File: rtl/wci_req_target.sv
// WCI request consumer: pops the FIFO head, executes control ops / config accesses, answers once.
// Latency: head seen at t -> req_deq at t, response at t+2; at most one request per 3 cycles.
// Backpressure: the FIFO is only popped in IDLE, so requests wait in the FIFO while one is in flight.
module wci_req_target
    import wci_pkg::*;
#(
    parameter int NREG = 8,
    parameter int RAW  = 3
) (
    input  logic               wciS0_Clk,
    input  logic               wciS0_MReset_n,
    wci_req_target_if.slave    wci,
    output logic [2:0]         ctl_state,
    output logic               is_operating,
    output logic               cfg_wr,
    output logic [NREG*32-1:0] cfg_regs
);

    req_fsm_t    state_q, state_d;
    wci_req_t    req_q;
    ctl_state_t  ctl_q, ctl_d;
    logic [1:0]  resp_q, resp_d;
    logic [31:0] data_q, data_d;
    logic        cfg_wr_q;
    logic        deq;
    logic        wr_commit;
    logic [RAW-1:0] cfg_idx;
    logic        cfg_oor;
    logic [31:0] cfg_rd_dat;
    logic        unused_addr_lsbs;

    assign cfg_idx          = req_q.addr[RAW+1:2];
    assign cfg_oor          = |req_q.addr[19:RAW+2];
    assign unused_addr_lsbs = ^req_q.addr[1:0];

    always_ff @(posedge wciS0_Clk or negedge wciS0_MReset_n) begin
        if (!wciS0_MReset_n) begin
            state_q  <= REQ_IDLE;
            req_q    <= '0;
            ctl_q    <= CTL_EXISTS;
            resp_q   <= SRESP_NULL;
            data_q   <= '0;
            cfg_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (deq) begin
                req_q <= wci.req_d_out;
            end
            ctl_q    <= ctl_d;
            resp_q   <= (state_q == REQ_EXEC) ? resp_d : SRESP_NULL;
            data_q   <= (state_q == REQ_EXEC) ? data_d : '0;
            cfg_wr_q <= (state_q == REQ_EXEC) && wr_commit;
        end
    end

    always_comb begin
        state_d   = state_q;
        deq       = 1'b0;
        resp_d    = SRESP_ERR;
        data_d    = '0;
        wr_commit = 1'b0;
        ctl_d     = ctl_q;
        case (state_q)
            REQ_IDLE: begin
                if (wci.req_empty_n) begin
                    deq     = 1'b1;
                    state_d = REQ_EXEC;
                end
            end
            REQ_EXEC: begin
                state_d = REQ_RESP;
                if (req_q.space) begin
                    if (!cfg_oor && req_q.mcmd == MCMD_WR) begin
                        wr_commit = 1'b1;
                        resp_d    = SRESP_DVA;
                    end else if (!cfg_oor && req_q.mcmd == MCMD_RD) begin
                        resp_d = SRESP_DVA;
                        data_d = cfg_rd_dat;
                    end
                end else if (req_q.mcmd == MCMD_RD) begin
                    // Illegal transitions still answer DVA; only the result word differs.
                    resp_d = SRESP_DVA;
                    data_d = CTL_RESULT_BAD;
                    case (req_q.addr[4:2])
                        OP_INIT: begin
                            if (ctl_q == CTL_EXISTS) begin
                                ctl_d  = CTL_INITIALIZED;
                                data_d = CTL_RESULT_OK;
                            end
                        end
                        OP_START: begin
                            if (ctl_q == CTL_INITIALIZED || ctl_q == CTL_SUSPENDED) begin
                                ctl_d  = CTL_OPERATING;
                                data_d = CTL_RESULT_OK;
                            end
                        end
                        OP_STOP: begin
                            if (ctl_q == CTL_OPERATING) begin
                                ctl_d  = CTL_SUSPENDED;
                                data_d = CTL_RESULT_OK;
                            end
                        end
                        OP_RELEASE: begin
                            ctl_d  = CTL_EXISTS;
                            data_d = CTL_RESULT_OK;
                        end
                        default: data_d = CTL_RESULT_OK;
                    endcase
                end
            end
            REQ_RESP: state_d = REQ_IDLE;
            default:  state_d = REQ_IDLE;
        endcase
    end

    wci_cfg_regfile #(.NREG(NREG), .RAW(RAW)) u_regfile (
        .clk       (wciS0_Clk),
        .rst_n     (wciS0_MReset_n),
        .wr_en     (wr_commit),
        .wr_idx    (cfg_idx),
        .wr_be     (req_q.byte_en),
        .wr_dat    (req_q.data),
        .rd_idx    (cfg_idx),
        .rd_dat    (cfg_rd_dat),
        .regs_flat (cfg_regs)
    );

    // Gate the pop with reset so nothing is dequeued while the block is held in reset.
    assign wci.req_deq     = deq & wciS0_MReset_n;
    assign wci.wciS0_SResp = resp_q;
    assign wci.wciS0_SData = data_q;
    assign cfg_wr          = cfg_wr_q;
    assign ctl_state       = ctl_q;
    assign is_operating    = (ctl_q == CTL_OPERATING);

endmodule

// File: tb/tb_wci_req_target.sv
// Scoreboard bench for wci_req_target: a queue-backed FIFO model feeds requests, a monitor checks responses.
module tb_wci_req_target;
    import wci_pkg::*;

    localparam int NREG = 8;
    localparam int RAW  = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wci_req_target_if ifc ();
    logic [2:0]         ctl_state;
    logic               is_operating;
    logic               cfg_wr;
    logic [NREG*32-1:0] cfg_regs;

    wci_req_target #(.NREG(NREG), .RAW(RAW)) dut (
        .wciS0_Clk      (clk),
        .wciS0_MReset_n (rst_n),
        .wci            (ifc),
        .ctl_state      (ctl_state),
        .is_operating   (is_operating),
        .cfg_wr         (cfg_wr),
        .cfg_regs       (cfg_regs)
    );

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
        logic        wr;
    } exp_t;

    logic [59:0] fifo_q [$];
    exp_t        sb_q [$];
    int          deq_cyc_q [$];
    int          deq_log [$];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic        deq_seen = 1'b0;
    exp_t        e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [59:0] mk(input logic [2:0] cmd, input logic space,
                                       input logic [3:0] be, input logic [19:0] addr,
                                       input logic [31:0] data);
        return {cmd, space, be, addr, data};
    endfunction

    task automatic send(input logic [2:0] cmd, input logic space, input logic [3:0] be,
                        input logic [19:0] addr, input logic [31:0] data,
                        input logic [1:0] eresp, input logic [31:0] edata, input logic ewr);
        exp_t x;
        x.resp = eresp;
        x.data = edata;
        x.wr   = ewr;
        fifo_q.push_back(mk(cmd, space, be, addr, data));
        sb_q.push_back(x);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((fifo_q.size() > 0 || sb_q.size() > 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (n >= 300) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d requests and %0d responses outstanding", fifo_q.size(), sb_q.size());
            fifo_q.delete();
            sb_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // FIFO model: pop after a cycle in which req_deq was seen, then present the new head.
    initial begin
        ifc.req_d_out   = '0;
        ifc.req_empty_n = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (deq_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
            ifc.req_empty_n = (fifo_q.size() > 0);
            ifc.req_d_out   = (fifo_q.size() > 0) ? fifo_q[0] : '0;
        end
    end

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        deq_seen = ifc.req_deq;
        if (ifc.req_deq) begin
            deq_cyc_q.push_back(cyc);
            deq_log.push_back(cyc);
        end
        if (ifc.wciS0_SResp != SRESP_NULL) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_resp", {62'd0, ifc.wciS0_SResp}, 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("sresp", {62'd0, ifc.wciS0_SResp}, {62'd0, e.resp});
                chk("sdata", {32'd0, ifc.wciS0_SData}, {32'd0, e.data});
                chk("cfg_wr_pulse", {63'd0, cfg_wr}, {63'd0, e.wr});
                if (deq_cyc_q.size() > 0) chk("latency", 64'(cyc - deq_cyc_q.pop_front()), 64'd2);
            end
        end else if (cfg_wr) begin
            chk("stray_cfg_wr", {63'd0, cfg_wr}, 64'd0);
        end else if (ifc.wciS0_SData != 32'd0) begin
            chk("idle_sdata", {32'd0, ifc.wciS0_SData}, 64'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREG*32-1:0] snap_regs;
        logic [2:0]         snap_state;
        logic [2:0]         ops [4]   = '{3'd0, 3'd1, 3'd2, 3'd1};
        logic [2:0]         states [4] = '{3'd1, 3'd2, 3'd3, 3'd2};
        logic [19:0]        addrs [4]  = '{20'h00000, 20'h00004, 20'h12348, 20'hFFF04};
        int                 base;
        int                 n;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_sresp", {62'd0, ifc.wciS0_SResp}, 64'd0);
        chk("rst_sdata", {32'd0, ifc.wciS0_SData}, 64'd0);
        chk("rst_ctl_state", {61'd0, ctl_state}, 64'd0);
        chk("rst_cfg_regs_lo", cfg_regs[63:0], 64'd0);
        chk("rst_cfg_regs_hi", cfg_regs[255:192], 64'd0);
        chk("rst_cfg_wr", {63'd0, cfg_wr}, 64'd0);
        rst_n = 1'b1;

        // Full-word write then read back (MAddr[1:0] ignored on the read).
        send(MCMD_WR, 1'b1, 4'hF, 20'h00008, 32'hDEADBEEF, SRESP_DVA, 32'd0, 1'b1);
        send(MCMD_RD, 1'b1, 4'hF, 20'h0000B, 32'd0, SRESP_DVA, 32'hDEADBEEF, 1'b0);
        wait_idle();
        chk("reg2_value", {32'd0, cfg_regs[95:64]}, 64'hDEADBEEF);

        // Byte-lane merge.
        send(MCMD_WR, 1'b1, 4'hF, 20'h00000, 32'h11223344, SRESP_DVA, 32'd0, 1'b1);
        send(MCMD_WR, 1'b1, 4'h5, 20'h00000, 32'hAABBCCDD, SRESP_DVA, 32'd0, 1'b1);
        send(MCMD_RD, 1'b1, 4'hF, 20'h00000, 32'd0, SRESP_DVA, 32'h11BB33DD, 1'b0);
        send(MCMD_WR, 1'b1, 4'h0, 20'h00000, 32'hFFFFFFFF, SRESP_DVA, 32'd0, 1'b1);
        wait_idle();
        chk("reg0_merge", {32'd0, cfg_regs[31:0]}, 64'h11BB33DD);

        // Control sequence init, start, stop, start (upper address bits ignored).
        for (int i = 0; i < 4; i++) begin
            send(MCMD_RD, 1'b0, 4'hF, addrs[i], 32'd0, SRESP_DVA, CTL_RESULT_OK, 1'b0);
            wait_idle();
            chk($sformatf("ctl_state_op%0d_step%0d", ops[i], i), {61'd0, ctl_state}, {61'd0, states[i]});
        end
        chk("is_operating", {63'd0, is_operating}, 64'd1);
        send(MCMD_RD, 1'b0, 4'hF, 20'h00000, 32'd0, SRESP_DVA, CTL_RESULT_BAD, 1'b0);
        wait_idle();
        chk("ctl_state_after_bad_init", {61'd0, ctl_state}, 64'd2);

        // Error cases: no side effects allowed.
        snap_regs  = cfg_regs;
        snap_state = ctl_state;
        send(MCMD_RD, 1'b1, 4'hF, 20'h00100, 32'd0, SRESP_ERR, 32'd0, 1'b0);
        send(MCMD_WR, 1'b1, 4'hF, 20'h00104, 32'h55555555, SRESP_ERR, 32'd0, 1'b0);
        send(MCMD_WR, 1'b0, 4'hF, 20'h0000C, 32'h12345678, SRESP_ERR, 32'd0, 1'b0);
        send(3'b011, 1'b1, 4'hF, 20'h00000, 32'hFFFFFFFF, SRESP_ERR, 32'd0, 1'b0);
        send(3'b000, 1'b0, 4'hF, 20'h0000C, 32'd0, SRESP_ERR, 32'd0, 1'b0);
        wait_idle();
        chk("err_regs_lo", cfg_regs[127:0] == snap_regs[127:0] ? 64'd1 : 64'd0, 64'd1);
        chk("err_regs_hi", cfg_regs[255:128] == snap_regs[255:128] ? 64'd1 : 64'd0, 64'd1);
        chk("err_ctl_state", {61'd0, ctl_state}, {61'd0, snap_state});

        // Back-to-back: four requests queued at once.
        deq_log.delete();
        send(MCMD_RD, 1'b1, 4'hF, 20'h00008, 32'd0, SRESP_DVA, 32'hDEADBEEF, 1'b0);
        send(MCMD_WR, 1'b1, 4'hF, 20'h0000C, 32'hCAFEF00D, SRESP_DVA, 32'd0, 1'b1);
        send(MCMD_RD, 1'b1, 4'hF, 20'h0000C, 32'd0, SRESP_DVA, 32'hCAFEF00D, 1'b0);
        send(MCMD_RD, 1'b0, 4'hF, 20'h00014, 32'd0, SRESP_DVA, CTL_RESULT_OK, 1'b0);
        wait_idle();
        chk("burst_deq_count", 64'(deq_log.size()), 64'd4);
        for (int i = 1; i < 4 && i < deq_log.size(); i++) begin
            chk($sformatf("burst_deq_spacing%0d", i), 64'(deq_log[i] - deq_log[i-1]), 64'd3);
        end

        // Reset while a config write to reg 1 is in EXEC.
        base = deq_log.size();
        send(MCMD_WR, 1'b1, 4'hF, 20'h00004, 32'h12345678, SRESP_DVA, 32'd0, 1'b1);
        send(MCMD_RD, 1'b1, 4'hF, 20'h00004, 32'd0, SRESP_DVA, 32'd0, 1'b0);
        n = 0;
        while (deq_log.size() == base && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("mid_exec_deq_seen", n < 50 ? 64'd1 : 64'd0, 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        if (sb_q.size() > 0) void'(sb_q.pop_front());
        if (deq_cyc_q.size() > 0) void'(deq_cyc_q.pop_front());
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_ctl_state", {61'd0, ctl_state}, 64'd0);
        chk("mid_rst_regs_lo", cfg_regs[127:0] == '0 ? 64'd1 : 64'd0, 64'd1);
        chk("mid_rst_regs_hi", cfg_regs[255:128] == '0 ? 64'd1 : 64'd0, 64'd1);
        chk("mid_rst_sresp", {62'd0, ifc.wciS0_SResp}, 64'd0);
        chk("mid_rst_deq", {63'd0, ifc.req_deq}, 64'd0);
        chk("mid_rst_cfg_wr", {63'd0, cfg_wr}, 64'd0);
        rst_n = 1'b1;
        wait_idle();
        chk("post_rst_reg1", {32'd0, cfg_regs[63:32]}, 64'd0);
        chk("post_rst_is_operating", {63'd0, is_operating}, 64'd0);

        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
